// File: rtl/instr_sequencer.sv
// ============================================================================
// instr_sequencer
// ----------------------------------------------------------------------------
// Purpose:
//   Small program store plus issue FSM that feeds a datapath one instruction
//   per cycle.  Software loads the store through the prog_* port while the
//   sequencer is not running, then pulses start with a program length.  The
//   sequencer issues entries 0 .. prog_len-1 in order.  It can be stalled
//   with hold and aborted with stop.  In the default build it finishes with
//   a single-cycle done pulse.
//
// Configuration:
//   INSTR_SEQ_LOOP_EN - when defined, the program wraps back to entry 0
//                       after its last entry and keeps issuing until stop
//                       or reset.  In this mode there is no done pulse.
//
// Parameters:
//   IW     instruction width
//   DEPTH  number of program-store entries (power of two)
//   AW     program address width, log2(DEPTH)
//
// Ports:
//   clk          in   rising-edge clock for all state
//   rst_n        in   asynchronous active-low reset
//   prog_we      in   program-store write strobe (accepted outside RUN)
//   prog_addr    in   program-store write address
//   prog_data    in   program-store write data
//   prog_len     in   instructions to issue, 1..DEPTH, sampled on start
//   start        in   begin execution at entry 0 (only from IDLE)
//   stop         in   abort execution (beats hold and issue)
//   hold         in   stall; nothing is issued while high
//   instr        out  registered instruction word to the datapath
//   instr_valid  out  instr carries a freshly issued word this cycle
//   pc           out  index of the next entry to issue
//   busy         out  high while running
//   done         out  one-cycle completion pulse
//   err          out  sticky error (bad length, or write while running)
//   issued_cnt   out  issues since the last accepted start, saturating
// ============================================================================
module instr_sequencer #(
    parameter int IW    = 16,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [IW-1:0] prog_data,
    input  logic [AW:0]   prog_len,
    input  logic          start,
    input  logic          stop,
    input  logic          hold,
    output logic [IW-1:0] instr,
    output logic          instr_valid,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [7:0]    issued_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [AW:0] DEPTH_LEN = (AW+1)'(DEPTH);

    state_t        state;
    logic [AW-1:0] last_idx;
    logic [IW-1:0] mem [DEPTH];
    logic          len_ok;
    logic          store_we;
    logic          last_issue;
    logic [7:0]    cnt_next;

    // A start is only accepted with a length the store can actually hold.
    assign len_ok = (prog_len != '0) && (prog_len <= DEPTH_LEN);

    // The store is frozen while running so an in-flight program cannot be
    // corrupted underneath the issue pointer.
    assign store_we = prog_we && (state != RUN);

    assign last_issue = (pc == last_idx);
    assign cnt_next   = (issued_cnt == 8'hFF) ? issued_cnt : issued_cnt + 8'd1;

    // Program store: deliberately has no reset so a program survives a
    // reset of the control logic.  A write on the same edge as an accepted
    // start lands before the first issue, which reads one edge later.
    always_ff @(posedge clk) begin
        if (store_we) begin
            mem[prog_addr] <= prog_data;
        end
    end

    // Issue FSM.  All outputs are registered here.  The length is kept as
    // the index of the last entry so the end-of-program compare is AW wide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            instr       <= '0;
            instr_valid <= 1'b0;
            pc          <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            issued_cnt  <= '0;
            last_idx    <= '0;
        end else begin
            instr_valid <= 1'b0;
            done        <= 1'b0;

            if (prog_we && (state == RUN)) begin
                err <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        if (len_ok) begin
                            last_idx   <= AW'(prog_len - (AW+1)'(1));
                            pc         <= '0;
                            issued_cnt <= '0;
                            err        <= 1'b0;
                            busy       <= 1'b1;
                            state      <= RUN;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end

                RUN: begin
                    if (stop) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (!hold) begin
                        instr       <= mem[pc];
                        instr_valid <= 1'b1;
                        issued_cnt  <= cnt_next;
                        if (last_issue) begin
                            pc <= '0;
`ifdef INSTR_SEQ_LOOP_EN
                            state <= RUN;
`else
                            busy  <= 1'b0;
                            state <= DONE;
`endif
                        end else begin
                            pc <= pc + AW'(1);
                        end
                    end
                end

                // The last word is still on instr_valid during this state,
                // so the done pulse appears on the edge leaving it.
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// ============================================================================
// tb_instr_sequencer
// ----------------------------------------------------------------------------
// Self-checking bench for instr_sequencer.  A plain array mirrors the program
// store, and the expected issue order is derived from it: entry k is the
// k-th word issued, and a hold cycle issues nothing.  Define
// INSTR_SEQ_LOOP_EN for both files to exercise the looping build.
// ============================================================================
module tb_instr_sequencer;

    localparam int IW    = 16;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          prog_we = 1'b0;
    logic [AW-1:0] prog_addr = '0;
    logic [IW-1:0] prog_data = '0;
    logic [AW:0]   prog_len = '0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          hold = 1'b0;
    logic [IW-1:0] instr;
    logic          instr_valid;
    logic [AW-1:0] pc;
    logic          busy;
    logic          done;
    logic          err;
    logic [7:0]    issued_cnt;

    logic [IW-1:0] ref_mem [DEPTH];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_sequencer #(.IW(IW), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .prog_len(prog_len), .start(start), .stop(stop),
        .hold(hold), .instr(instr), .instr_valid(instr_valid), .pc(pc),
        .busy(busy), .done(done), .err(err), .issued_cnt(issued_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input int addr, input logic [IW-1:0] data);
        prog_we   = 1'b1;
        prog_addr = AW'(addr);
        prog_data = data;
        tick();
        prog_we = 1'b0;
        ref_mem[addr] = data;
    endtask

    // Tail of a program: completion pulse, or in loop mode an explicit stop.
    task automatic finish_program(input int len, input string name);
`ifdef INSTR_SEQ_LOOP_EN
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++;
        if (busy !== 1'b0 || instr_valid !== 1'b0 || done !== 1'b0 || issued_cnt !== 8'(len)) begin
            errors++;
            $display("[TB] FAIL %s_stop got busy=%0b valid=%0b done=%0b cnt=%0d want 0 0 0 %0d",
                     name, busy, instr_valid, done, issued_cnt, len);
        end
`else
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s_last got busy=%0b done=%0b want 0 0", name, busy, done);
        end
        tick();
        checks++;
        if (done !== 1'b1 || instr_valid !== 1'b0 || busy !== 1'b0 || pc !== '0 ||
            issued_cnt !== 8'(len) || instr !== ref_mem[len-1]) begin
            errors++;
            $display("[TB] FAIL %s_done got done=%0b valid=%0b busy=%0b pc=%0d cnt=%0d instr=%h want 1 0 0 0 %0d %h",
                     name, done, instr_valid, busy, pc, issued_cnt, instr, len, ref_mem[len-1]);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s_after got done=%0b busy=%0b want 0 0", name, done, busy);
        end
`endif
    endtask

    // Start a program of len entries; bit c of hold_mask stalls cycle c of
    // RUN.  With noise set, start is toggled with random lengths while
    // running, which must have no effect.
    task automatic run_and_check(input int len, input logic [63:0] hold_mask,
                                 input bit noise, input string name);
        int k = 0;
        int c = 0;
        bit h;
        prog_len = (AW+1)'(len);
        start = 1'b1;
        tick();
        start   = 1'b0;
        prog_we = 1'b0;
        checks++;
        if (busy !== 1'b1 || instr_valid !== 1'b0 || err !== 1'b0 || issued_cnt !== 8'd0 || pc !== '0) begin
            errors++;
            $display("[TB] FAIL %s_accept got busy=%0b valid=%0b err=%0b cnt=%0d pc=%0d want 1 0 0 0 0",
                     name, busy, instr_valid, err, issued_cnt, pc);
        end
        while (k < len) begin
            h = (c < 64) ? hold_mask[c] : 1'b0;
            hold  = h;
            start = noise ? 1'($urandom_range(1)) : 1'b0;
            if (noise) prog_len = (AW+1)'($urandom_range(31));
            tick();
            c++;
            if (h) begin
                checks++;
                if (instr_valid !== 1'b0 || pc !== AW'(k) || (k > 0 && instr !== ref_mem[k-1])) begin
                    errors++;
                    $display("[TB] FAIL %s_hold c=%0d got valid=%0b pc=%0d instr=%h want 0 %0d",
                             name, c, instr_valid, pc, instr, k);
                end
            end else begin
                checks++;
                if (instr_valid !== 1'b1 || instr !== ref_mem[k]) begin
                    errors++;
                    $display("[TB] FAIL %s_issue k=%0d got valid=%0b instr=%h want 1 %h",
                             name, k, instr_valid, instr, ref_mem[k]);
                end
                k++;
                checks++;
                if (issued_cnt !== 8'(k) || pc !== AW'(k % len) || err !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL %s_count k=%0d got cnt=%0d pc=%0d err=%0b want %0d %0d 0",
                             name, k, issued_cnt, pc, err, k, k % len);
                end
            end
        end
        hold  = 1'b0;
        start = 1'b0;
        finish_program(len, name);
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #10;
        checks++;
        if ({instr, instr_valid, pc, busy, done, err, issued_cnt} !== '0) begin
            errors++;
            $display("[TB] FAIL reset got instr=%h valid=%0b pc=%0d busy=%0b done=%0b err=%0b cnt=%0d want all 0",
                     instr, instr_valid, pc, busy, done, err, issued_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        load_word(0, 16'h0A50);
        load_word(1, 16'hB012);
        load_word(2, 16'hD013);
        run_and_check(3, 64'd0, 1'b0, "basic");
    endtask

    task automatic test_hold();
        run_and_check(3, 64'b110, 1'b0, "hold");
    endtask

    task automatic test_errors();
        prog_len = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL len0 got err=%0b busy=%0b want 1 0", err, busy);
        end
        prog_len = 5'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL err_clear got err=%0b busy=%0b want 0 1", err, busy);
        end
        prog_we   = 1'b1;
        prog_addr = 4'd1;
        prog_data = ~ref_mem[1];
        tick();
        prog_we = 1'b0;
        checks++;
        if (err !== 1'b1 || instr_valid !== 1'b1 || instr !== ref_mem[0]) begin
            errors++;
            $display("[TB] FAIL we_run got err=%0b valid=%0b instr=%h want 1 1 %h", err, instr_valid, instr, ref_mem[0]);
        end
        for (int i = 1; i < 3; i++) begin
            tick();
            checks++;
            if (instr_valid !== 1'b1 || instr !== ref_mem[i] || err !== 1'b1) begin
                errors++;
                $display("[TB] FAIL store_kept i=%0d got valid=%0b instr=%h err=%0b want 1 %h 1",
                         i, instr_valid, instr, err, ref_mem[i]);
            end
        end
`ifdef INSTR_SEQ_LOOP_EN
        stop = 1'b1;
        tick();
        stop = 1'b0;
`else
        tick();
        tick();
`endif
        prog_len = 5'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b1;
        tick();
        stop = 1'b0;
        checks++;
        if (err !== 1'b0 || busy !== 1'b0 || issued_cnt !== 8'd0 || instr_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stop_first got err=%0b busy=%0b cnt=%0d valid=%0b want 0 0 0 0",
                     err, busy, issued_cnt, instr_valid);
        end
        prog_len = 5'd17;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checks++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL len17 got err=%0b busy=%0b want 1 0", err, busy);
        end
    endtask

    task automatic test_same_edge_write();
        logic [IW-1:0] w;
        w = IW'($urandom);
        prog_we   = 1'b1;
        prog_addr = '0;
        prog_data = w;
        ref_mem[0] = w;
        run_and_check(3, 64'd0, 1'b0, "same_edge");
    endtask

    task automatic test_stop_hold();
        for (int a = 0; a < DEPTH; a++) load_word(a, IW'($urandom));
        prog_len = 5'd16;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (instr_valid !== 1'b1 || instr !== ref_mem[i]) begin
                errors++;
                $display("[TB] FAIL sh_issue i=%0d got valid=%0b instr=%h want 1 %h", i, instr_valid, instr, ref_mem[i]);
            end
        end
        stop = 1'b1;
        hold = 1'b1;
        tick();
        stop = 1'b0;
        hold = 1'b0;
        checks++;
        if (busy !== 1'b0 || instr_valid !== 1'b0 || issued_cnt !== 8'd4 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sh_stop got busy=%0b valid=%0b cnt=%0d done=%0b want 0 0 4 0",
                     busy, instr_valid, issued_cnt, done);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (done !== 1'b0 || instr_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL sh_quiet got done=%0b valid=%0b want 0 0", done, instr_valid);
            end
        end
    endtask

    task automatic test_async_reset();
        prog_len = 5'd16;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({instr, instr_valid, pc, busy, done, err, issued_cnt} !== '0) begin
            errors++;
            $display("[TB] FAIL async_rst got instr=%h valid=%0b pc=%0d busy=%0b done=%0b err=%0b cnt=%0d want all 0",
                     instr, instr_valid, pc, busy, done, err, issued_cnt);
        end
        #2 rst_n = 1'b1;
        tick();
        run_and_check(16, 64'd0, 1'b0, "post_reset");
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            int n;
            n = $urandom_range(6, 1);
            for (int w = 0; w < n; w++) load_word($urandom_range(DEPTH-1), IW'($urandom));
            run_and_check($urandom_range(DEPTH, 1), {$urandom, $urandom} & {$urandom, $urandom}, 1'b1, "random");
        end
    endtask

`ifdef INSTR_SEQ_LOOP_EN
    task automatic test_loop();
        load_word(0, IW'($urandom));
        load_word(1, IW'($urandom));
        prog_len = 5'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            checks++;
            if (instr_valid !== 1'b1 || instr !== ref_mem[i % 2] || done !== 1'b0 ||
                issued_cnt !== 8'((i + 1 > 255) ? 255 : i + 1)) begin
                errors++;
                $display("[TB] FAIL loop i=%0d got valid=%0b instr=%h done=%0b cnt=%0d want 1 %h 0 %0d",
                         i, instr_valid, instr, done, issued_cnt, ref_mem[i % 2], (i + 1 > 255) ? 255 : i + 1);
            end
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++;
        if (busy !== 1'b0 || instr_valid !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL loop_stop got busy=%0b valid=%0b done=%0b want 0 0 0", busy, instr_valid, done);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_errors();
        test_same_edge_write();
        test_stop_hold();
        test_async_reset();
        test_random();
`ifdef INSTR_SEQ_LOOP_EN
        test_loop();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter: IW, 16, instruction width; SHALL match the datapath instruction word.
REQ-002 Parameter: DEPTH, 16, program store entries; SHALL be a power of two.
REQ-003 Parameter: AW, 4, program address width; SHALL equal log2(DEPTH).
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 prog_we  in  1  program-store write strobe.
REQ-007 prog_addr  in  AW  program-store write address.
REQ-008 prog_data  in  IW  program-store write data.
REQ-009 prog_len  in  AW+1  number of instructions to issue; legal range 1..DEPTH; sampled on accepted start.
REQ-010 start  in  1  begin execution at entry 0.
REQ-011 stop  in  1  abort execution.
REQ-012 hold  in  1  stall; no issue in a cycle where hold=1.
REQ-013 instr  out  IW  instruction to the datapath; registered.
REQ-014 instr_valid  out  1  instr is valid; the integrator SHALL gate the datapath clock enable with it.
REQ-015 pc  out  AW  index of the next entry to issue.
REQ-016 busy  out  1  high in RUN.
REQ-017 done  out  1  one-cycle pulse when the program completes.
REQ-018 err  out  1  sticky error flag.
REQ-019 issued_cnt  out  8  instructions issued since the last accepted start; saturates at 255.

Function
REQ-020 FSM states SHALL be IDLE, RUN and DONE; the reset state SHALL be IDLE.
REQ-021 IDLE: start=1 with prog_len in 1..DEPTH SHALL latch prog_len, clear pc, issued_cnt and err, and go to RUN.
REQ-022 IDLE: start=1 with prog_len=0 or prog_len>DEPTH SHALL set err and remain in IDLE.
REQ-023 RUN, hold=0, stop=0: SHALL register instr<=mem[pc], instr_valid<=1, pc<=pc+1 and issued_cnt+1 (saturating).
REQ-024 Latency: the first instr_valid SHALL be high in the cycle after the edge on which start was accepted.
REQ-025 RUN, hold=1: instr_valid SHALL be 0; pc, instr and issued_cnt SHALL hold.
REQ-026 RUN, stop=1: SHALL go to IDLE and set instr_valid=0 on that edge; stop SHALL win over hold and over issue; done SHALL NOT pulse.
REQ-027 Issuing entry latched_len-1 SHALL move the FSM to DONE; pc SHALL wrap to 0.
REQ-028 DONE: SHALL assert done=1 and instr_valid=0 for exactly one cycle, then go to IDLE.
REQ-029 prog_we in IDLE or DONE SHALL write mem[prog_addr]<=prog_data.
REQ-030 prog_we in RUN SHALL be ignored and SHALL set err.
REQ-031 prog_we and accepted start on the same edge: the write SHALL complete, and the first issue SHALL see the new data.
REQ-032 start in RUN or DONE SHALL be ignored without an error.
REQ-033 When instr_valid=0, instr SHALL hold its last value.

Reset
REQ-034 rst_n=0 SHALL immediately force IDLE, instr=0, instr_valid=0, pc=0, busy=0, done=0, err=0 and issued_cnt=0, including mid-RUN.
REQ-035 Program-store contents SHALL NOT be cleared by reset.

Configuration
REQ-036 Macro INSTR_SEQ_LOOP_EN: when defined, issuing entry latched_len-1 SHALL wrap pc to 0 and stay in RUN with no done pulse; only stop or reset SHALL end execution.
REQ-037 When INSTR_SEQ_LOOP_EN is not defined, REQ-027 and REQ-028 SHALL apply.

Verification
REQ-038 Load 3 entries (0x0A50, 0xB012, 0xD013) with prog_len=3, then start -> instr_valid high for 3 consecutive cycles carrying those words; then done pulses once; issued_cnt=3; busy low afterwards.
REQ-039 Same program with hold=1 for 2 cycles after the first issue -> 2 cycles with instr_valid=0 and pc=1; then 0xB012 and 0xD013 are issued; issued_cnt=3.
REQ-040 prog_len=16 with stop=1 and hold=1 asserted together on the 5th RUN cycle -> IDLE on the next edge; issued_cnt=4; done is never asserted.
REQ-041 start with prog_len=0 -> err=1 and busy=0; prog_we during RUN -> err=1 and the store is unchanged; a later valid start -> err clears.
REQ-042 rst_n pulled low mid-RUN (asynchronously, between edges) -> all outputs are zero immediately; after release and a new start, the program store still returns the old contents.
REQ-043 INSTR_SEQ_LOOP_EN defined, prog_len=2 -> the sequence e0,e1,e0,e1,... continues with no done pulse until stop; issued_cnt saturates at 255.
